// File: rtl/mmio_display_pkg.sv
// mmio_display_pkg
// Shared constants for the MMIO display controller: register word offsets,
// CTRL field positions and the hex-to-7-segment table (active-low, bit 0 = a).
package mmio_display_pkg;

  localparam logic [2:0] REG_SW    = 3'd0;
  localparam logic [2:0] REG_BTN   = 3'd1;
  localparam logic [2:0] REG_DATA  = 3'd2;
  localparam logic [2:0] REG_CTRL  = 3'd3;
  localparam logic [2:0] REG_EVENT = 3'd4;

  localparam int unsigned CTRL_EN_LSB    = 0;
  localparam int unsigned CTRL_DP_LSB    = 8;
  localparam int unsigned CTRL_BLANK_BIT = 16;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [6:0] seg_tbl_t [16];

  // Index = nibble value; segments are active-low with bit 0 = a, bit 6 = g.
  localparam seg_tbl_t HEX_SEG = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/mmio_display_ctrl_btn_debounce.sv
// btn_debounce
// One push-button channel: 2-flop synchroniser followed by a stability
// counter. The debounced level only follows the synchronised input after it
// has differed from the current level for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   btn_i    raw, bouncing, asynchronous button input
//   level_o  debounced level
//   rise_o   one-cycle pulse, high in the cycle whose edge raises level_o
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned     CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised input agrees with the level restarts
  // the count, so every bounce back discards the partial run.
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (s2_q != lvl_q) begin
      if (cnt_q == LAST) begin
        lvl_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= btn_i;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = lvl_d & ~lvl_q;

endmodule

// File: rtl/mmio_display_ctrl.sv
// mmio_display_ctrl
// Memory-mapped peripheral: reads slide switches and debounced push buttons,
// latches button press events, and multiplexes a bank of 7-segment digits.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   sel, we, addr, wdata  bus access (word offset addr), writes on clk edge
//   rdata                 combinational read data, 0 when sel is low
//   sw, btn               raw asynchronous switch / button inputs
//   an, a2g, dp           registered, active-low digit anodes / segments / dp
module mmio_display_ctrl
  import mmio_display_pkg::*;
#(
  parameter int unsigned NDIGITS         = 8,
  parameter int unsigned NSW             = 16,
  parameter int unsigned NBTN            = 3,
  parameter int unsigned SCAN_DIV        = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sel,
  input  logic                we,
  input  logic [2:0]          addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  input  logic [NSW-1:0]      sw,
  input  logic [NBTN-1:0]     btn,
  output logic [NDIGITS-1:0]  an,
  output logic [6:0]          a2g,
  output logic                dp
);

  localparam int unsigned DW        = $clog2(SCAN_DIV);
  localparam int unsigned IW        = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int unsigned DATA_BITS = 4 * NDIGITS;

  logic [NSW-1:0]       sw_s1_q, sw_s2_q;
  logic [NBTN-1:0]      btn_lvl, btn_rise;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic [NDIGITS-1:0]   en_q, en_d;
  logic [NDIGITS-1:0]   dpm_q, dpm_d;
  logic                 blank_q, blank_d;
  logic [NBTN-1:0]      event_q, event_d;
  logic [NBTN-1:0]      evt_clr;

  logic [DW-1:0]        div_q, div_d;
  logic [IW-1:0]        idx_q, idx_d;

  logic [NDIGITS-1:0]   an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;

  logic                 wr_en;
  assign wr_en = sel & we;

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .btn_i   (btn[g]),
      .level_o (btn_lvl[g]),
      .rise_o  (btn_rise[g])
    );
  end

  // Register writes. Events are write-1-to-clear, but a rise in the same
  // cycle re-sets the bit so no press is lost.
  always_comb begin
    data_d  = data_q;
    en_d    = en_q;
    dpm_d   = dpm_q;
    blank_d = blank_q;
    evt_clr = '0;
    if (wr_en) begin
      case (addr)
        REG_DATA: data_d = wdata[DATA_BITS-1:0];
        REG_CTRL: begin
          en_d    = wdata[CTRL_EN_LSB +: NDIGITS];
          dpm_d   = wdata[CTRL_DP_LSB +: NDIGITS];
          blank_d = wdata[CTRL_BLANK_BIT];
        end
        REG_EVENT: evt_clr = wdata[NBTN-1:0];
        default: ;
      endcase
    end
    event_d = (event_q & ~evt_clr) | btn_rise;
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        REG_SW:    rdata = 32'(sw_s2_q);
        REG_BTN:   rdata = 32'(btn_lvl);
        REG_DATA:  rdata = 32'(data_q);
        REG_CTRL: begin
          rdata[CTRL_EN_LSB +: NDIGITS] = en_q;
          rdata[CTRL_DP_LSB +: NDIGITS] = dpm_q;
          rdata[CTRL_BLANK_BIT]         = blank_q;
        end
        REG_EVENT: rdata = 32'(event_q);
        default:   rdata = '0;
      endcase
    end
  end

  // Scan divider and digit index.
  always_comb begin
    div_d = div_q + DW'(1);
    idx_d = idx_q;
    if (div_q == DW'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Digit decode from the current index; the result is registered so the
  // pins change one cycle after the index or register contents.
  always_comb begin
    logic [3:0] nib;
    logic       hi_zero;
    nib     = '0;
    hi_zero = 1'b0;
    an_d    = '1;
    dp_d    = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib     = data_q[4*i +: 4];
        an_d[i] = ~en_q[i];
        dp_d    = ~dpm_q[i];
        // Leading zero: this nibble and every higher one are zero.
        hi_zero = (i != 0) && ((data_q >> (4*i)) == '0);
      end
    end
    seg_d = (blank_q && hi_zero) ? SEG_BLANK : hex_to_seg(nib);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      data_q  <= '0;
      en_q    <= '0;
      dpm_q   <= '0;
      blank_q <= 1'b0;
      event_q <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
      data_q  <= data_d;
      en_q    <= en_d;
      dpm_q   <= dpm_d;
      blank_q <= blank_d;
      event_q <= event_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign a2g = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_mmio_display_ctrl.sv
module tb_mmio_display_ctrl;

  localparam int NDIGITS  = 8;
  localparam int NSW      = 16;
  localparam int NBTN     = 3;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b1;
  logic              sel     = 1'b0;
  logic              we      = 1'b0;
  logic [2:0]        addr    = '0;
  logic [31:0]       wdata   = '0;
  logic [31:0]       rdata;
  logic [NSW-1:0]    sw      = '0;
  logic [NBTN-1:0]   btn     = '0;
  logic [NDIGITS-1:0] an;
  logic [6:0]        a2g;
  logic              dp;

  always #5 clk = ~clk;

  mmio_display_ctrl #(
    .NDIGITS(NDIGITS), .NSW(NSW), .NBTN(NBTN),
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .sw(sw), .btn(btn),
    .an(an), .a2g(a2g), .dp(dp)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural reference model.
  logic [31:0]      m_data;
  logic [7:0]       m_en, m_dpm;
  logic             m_blank;
  logic [NBTN-1:0]  m_event, m_deb, m_s1, m_s2;
  logic [NSW-1:0]   m_sw1, m_sw2;
  logic [DEB-1:0]   m_hist [NBTN];
  int               m_hlen [NBTN];
  int               m_cyc;
  int               t_rise;
  logic [7:0]       e_an;
  logic [6:0]       e_seg;
  logic             e_dp;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; 4'hF: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic model_reset();
    m_data = '0; m_en = '0; m_dpm = '0; m_blank = 1'b0;
    m_event = '0; m_deb = '0; m_s1 = '0; m_s2 = '0;
    m_sw1 = '0; m_sw2 = '0; m_cyc = 0; t_rise = 0;
    for (int b = 0; b < NBTN; b++) begin
      m_hist[b] = '0;
      m_hlen[b] = 0;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {16'b0, m_sw2};
      3'd1: return {29'b0, m_deb};
      3'd2: return m_data;
      3'd3: return {15'b0, m_blank, m_dpm, m_en};
      3'd4: return {29'b0, m_event};
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the reference: outputs come from the state before the
  // edge; then buttons, events, registers and synchronisers advance.
  task automatic model_step();
    int              idx;
    logic            bl;
    logic [NBTN-1:0] rise, clr;
    idx   = (m_cyc / SCAN_DIV) % NDIGITS;
    bl    = m_blank && (idx != 0) && ((m_data >> (4 * idx)) == 32'h0);
    e_an  = m_en[idx] ? ~(8'h01 << idx) : 8'hFF;
    e_seg = bl ? 7'h7F : seg_of(m_data[4*idx +: 4]);
    e_dp  = ~m_dpm[idx];
    rise  = '0;
    for (int b = 0; b < NBTN; b++) begin
      m_hist[b] = {m_hist[b][DEB-2:0], m_s2[b]};
      if (m_hlen[b] < DEB) m_hlen[b]++;
      if (m_hlen[b] == DEB && m_hist[b] == {DEB{~m_deb[b]}}) begin
        rise[b]  = ~m_deb[b];
        m_deb[b] = ~m_deb[b];
      end
    end
    clr = (sel && we && addr == 3'd4) ? wdata[NBTN-1:0] : '0;
    m_event = (m_event & ~clr) | rise;
    if (sel && we) begin
      if (addr == 3'd2) m_data = wdata;
      if (addr == 3'd3) begin
        m_en = wdata[7:0]; m_dpm = wdata[15:8]; m_blank = wdata[16];
      end
    end
    if (m_s1[0] && !m_s2[0]) t_rise = m_cyc + 1;
    m_s2 = m_s1; m_s1 = btn;
    m_sw2 = m_sw1; m_sw1 = sw;
    m_cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("a2g", 32'(a2g), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    chk(tag, rdata, model_read(a));
    sel = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_a2g", 32'(a2g), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  function automatic logic rise_next(input int b);
    return !m_deb[b] && m_s2[b] && (m_hlen[b] >= DEB - 1) &&
           (m_hist[b][DEB-2:0] == {(DEB-1){1'b1}});
  endfunction

  initial begin
    int   cnt0, cntff, lat_seen, done;
    logic [31:0] v;
    #2;
    apply_reset();
    for (int a = 0; a < 5; a++) rd_chk("rst_reg", 3'(a));
    sel = 1'b1; addr = 3'd2; #1;
    chk("rst_data_zero", rdata, 32'h0);
    sel = 1'b0;

    // Two digits enabled, each held SCAN_DIV cycles per scan.
    bus_write(3'd2, 32'h0000_00A5);
    bus_write(3'd3, 32'h0000_0003);
    cnt0 = 0; cntff = 0;
    for (int c = 0; c < 64; c++) begin
      tick();
      if (an == 8'hFE) begin cnt0++; chk("d0_seg", 32'(a2g), 32'h12); end
      if (an == 8'hFD) chk("d1_seg", 32'(a2g), 32'h08);
      if (an == 8'hFF) cntff++;
    end
    chk("d0_hold", 32'(cnt0), 32'd8);
    chk("off_cycles", 32'(cntff), 32'd48);

    // Leading-zero blanking.
    bus_write(3'd3, 32'h0001_00FF);
    bus_write(3'd2, 32'h0000_0100);
    rd_chk("ctrl_rb", 3'd3);
    for (int c = 0; c < 32; c++) begin
      tick();
      for (int d = 0; d < NDIGITS; d++) begin
        if (an == ~(8'h01 << d)) begin
          if (d >= 3)      chk("blank_seg", 32'(a2g), 32'h7F);
          else if (d == 2) chk("d2_seg", 32'(a2g), 32'h79);
          else             chk("zero_seg", 32'(a2g), 32'h40);
        end
      end
    end

    // Bouncing press, then held.
    for (int c = 0; c < 20; c++) begin
      btn[0] = ((c / 3) % 2 == 0);
      tick();
    end
    btn[0] = 1'b1;
    lat_seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      sel = 1'b1; addr = 3'd1; #1;
      chk("btn_rd", rdata, model_read(3'd1));
      if (rdata[0] && lat_seen == 0) begin
        lat_seen = 1;
        chk("btn_latency", 32'(m_cyc - t_rise), 32'd8);
      end
      sel = 1'b0;
    end
    chk("btn_rise_seen", 32'(lat_seen), 32'd1);
    rd_chk("event_model", 3'd4);
    sel = 1'b1; addr = 3'd4; #1;
    chk("event_set", rdata, 32'h1);
    sel = 1'b0;

    // Clear, release, then clear in the same cycle as a new rise.
    bus_write(3'd4, 32'h1);
    sel = 1'b1; addr = 3'd4; #1;
    chk("event_clr", rdata, 32'h0);
    sel = 1'b0;
    btn[0] = 1'b0;
    for (int c = 0; c < 30 && m_deb[0]; c++) tick();
    chk("btn_released", 32'(m_deb[0]), 32'h0);
    btn[0] = 1'b1;
    done = 0;
    for (int c = 0; c < 30 && done == 0; c++) begin
      if (rise_next(0)) begin
        bus_write(3'd4, 32'h1);
        done = 1;
      end else begin
        tick();
      end
    end
    chk("rise_clr_hit", 32'(done), 32'd1);
    sel = 1'b1; addr = 3'd4; #1;
    chk("set_wins", rdata, 32'h1);
    sel = 1'b0;
    repeat (3) tick();
    bus_write(3'd4, 32'h1);
    sel = 1'b1; addr = 3'd4; #1;
    chk("event_clr2", rdata, 32'h0);
    sel = 1'b0;

    // Reset mid-scan at digit 5 with a debounce in progress.
    btn[0] = 1'b0;
    bus_write(3'd3, 32'h0000_00FF);
    bus_write(3'd2, 32'h1234_5678);
    for (int c = 0; c < 40 && ((m_cyc / SCAN_DIV) % NDIGITS) != 5; c++) tick();
    chk("at_digit5", 32'((m_cyc / SCAN_DIV) % NDIGITS), 32'd5);
    btn[1] = 1'b1;
    repeat (6) tick();
    sel = 1'b1; addr = 3'd1; #1;
    chk("btn1_pending", 32'(rdata[1]), 32'h0);
    sel = 1'b0;
    apply_reset();
    for (int c = 0; c < 14; c++) begin
      tick();
      rd_chk("btn_after_rst", 3'd1);
      if (c == 0) begin
        sel = 1'b1; addr = 3'd1; #1;
        chk("btn_zero_after_rst", rdata, 32'h0);
        sel = 1'b0;
      end
    end
    bus_write(3'd3, 32'h0000_00FF);
    repeat (40) tick();
    btn[1] = 1'b0;

    // Randomised register traffic, switches and slow button activity.
    for (int it = 0; it < 60; it++) begin
      sw = NSW'($urandom);
      btn[2] = 1'($urandom_range(0, 1));
      v = $urandom;
      case ($urandom_range(0, 4))
        0: bus_write(3'd2, v);
        1: bus_write(3'd3, v);
        2: bus_write(3'($urandom_range(0, 7)), v);
        3: bus_write(3'd4, v);
        default: tick();
      endcase
      repeat ($urandom_range(1, 14)) tick();
      rd_chk("rnd_rd", 3'($urandom_range(0, 7)));
      rd_chk("rnd_sw", 3'd0);
      rd_chk("rnd_evt", 3'd4);
      addr = 3'($urandom_range(0, 7)); #1;
      chk("rd_nosel", rdata, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mmio_display_ctrl.md
MMIO_DISPLAY_CTRL -- requirements
Module: mmio_display_ctrl

Interface
REQ-001 Parameter NDIGITS, default 8, number of 7-segment digits (1..8).
REQ-002 Parameter NSW, default 16, number of switch inputs (1..16).
REQ-003 Parameter NBTN, default 3, number of push-button inputs (1..8).
REQ-004 Parameter SCAN_DIV, default 100000, clk cycles each digit is driven (>=2).
REQ-005 Parameter DEBOUNCE_CYCLES, default 1000000, stable cycles before a button change is accepted (>=2).
REQ-006 clk  in  1  single system clock; all state changes on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 sel  in  1  chip select from the system address decoder; high = bus access targets this block.
REQ-009 we  in  1  write enable, qualified by sel.
REQ-010 addr  in  3  word offset within the block (byte address bits [4:2]).
REQ-011 wdata  in  32  write data.
REQ-012 rdata  out  32  read data, combinational from addr; 0 when sel low.
REQ-013 sw  in  NSW  raw slide switches, asynchronous to clk.
REQ-014 btn  in  NBTN  raw push buttons, active-high, asynchronous, bouncing.
REQ-015 an  out  NDIGITS  digit anodes, active-low.
REQ-016 a2g  out  7  segments a..g, active-low, bit 0 = a.
REQ-017 dp  out  1  decimal point, active-low.

Function
REQ-018 Register map (offset): 0 SW (RO), 1 BTN (RO, debounced level), 2 DATA (RW, 4 bits per digit, digit 0 = bits [3:0]), 3 CTRL (RW), 4 EVENT (RO read, write-1-to-clear).
REQ-019 CTRL fields: [7:0] digit enable mask, [15:8] decimal-point mask, [16] leading-zero blanking; bits above NDIGITS in the masks read 0.
REQ-020 Writes take effect at the rising edge where sel=1 and we=1; reads of unmapped offsets 5..7 return 0, and writes to them are ignored.
REQ-021 sw and btn each pass through a 2-flop synchroniser; SW reads the synchronised value, zero-extended.
REQ-022 Debounce per button: a counter restarts on every synchronised change; the debounced level updates only after DEBOUNCE_CYCLES consecutive cycles with the synchronised value differing from the debounced level.
REQ-023 A debounced 0->1 transition sets EVENT[i]; the bit stays set until cleared by writing 1; if set and clear occur in the same cycle, set wins.
REQ-024 Scan: a divider counts 0..SCAN_DIV-1; on wrap, digit index advances and wraps from NDIGITS-1 to 0.
REQ-025 On every cycle, an drives exactly one low bit (the current index) if that digit is enabled, otherwise all ones.
REQ-026 a2g is the hex decode (0-F) of the current digit nibble; dp is low iff the DP mask bit for the current index is set.
REQ-027 With blanking on, a digit whose nibble and all higher-index nibbles are 0 is blank (a2g all ones); digit 0 is never blanked.
REQ-028 an, a2g and dp are registered: they change one cycle after the index or register update.

Reset
REQ-029 While reset_n low: DATA=0, CTRL=0, EVENT=0, debounced BTN=0, synchronisers=0, divider=0, index=0.
REQ-030 While reset_n low: an all ones, a2g all ones, dp=1.
REQ-031 A reset mid-debounce discards the partial count; a reset mid-scan restarts at digit 0.

Structure
REQ-032 Package mmio_display_pkg holds register offset constants, CTRL field positions, and the 16-entry hex-to-segment table.
REQ-033 Sub-module btn_debounce (synchroniser plus counter for one button) is instantiated NBTN times.

Verification
REQ-034 Use SCAN_DIV=4, DEBOUNCE_CYCLES=8 for the bench.
REQ-035 Reset, then write DATA=0x0000_00A5 and CTRL=0x0000_0003 -> digit 0 shows 5 (a2g=0x12), digit 1 shows A (a2g=0x08), digits 2..7 have an high; each digit is held 4 cycles.
REQ-036 Set CTRL=0x1_00FF with DATA=0x0000_0100 -> digits 3..7 blank, digit 2 shows 1 (a2g=0x79), digits 1 and 0 show 0 (a2g=0x40).
REQ-037 Bounce btn[0] every 3 cycles for 20 cycles, then hold it high -> BTN[0]=1 exactly 8 cycles after the synchronised input becomes stable, and EVENT=0x1.
REQ-038 Write EVENT=0x1 in the same cycle as a new btn[0] debounced rise -> EVENT[0] stays 1; a later write of 0x1 with no rise -> EVENT=0.
REQ-039 Assert reset_n low mid-scan at digit 5 with a pending debounce -> outputs all ones immediately, with no clock edge required; after release, the scan restarts at digit 0 and BTN=0.
